// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and frame constants shared by the UART transmitter and receiver.
package uart_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;
   localparam int DATA_BITS     = 8;
   localparam int MAX_STOP_BITS = 2;
endpackage

// File: rtl/uart_parity_gen.sv
// uart_parity_gen: even or odd parity over one data word.
module uart_parity_gen
   import uart_pkg::*;
#(
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic [DATA_BITS-1:0] data_i,
   output logic                 parity_o
);
   assign parity_o = PARITY_ODD ? ~^data_i : ^data_i;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter with a one-entry holding register for gapless frames.
module uart_tx
   import uart_pkg::*;
#(
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 bit_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 busy,
   output logic                 tx_done
);
   localparam int CW = $clog2(DATA_BITS);
   localparam int SW = $clog2(MAX_STOP_BITS);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, hold_data_q, hold_data_d;
   logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [SW-1:0]        stop_cnt_q, stop_cnt_d;
   logic                 hold_full_q, hold_full_d;
   logic                 par_q, par_d, txd_q, txd_d, done_q, done_d;
   logic                 par_new, last_stop;

   uart_parity_gen #(.PARITY_ODD(PARITY_ODD)) u_par (
      .data_i  (hold_data_q),
      .parity_o(par_new)
   );

   assign last_stop = int'(stop_cnt_q) >= STOP_BITS - 1;
   assign tx_ready  = !hold_full_q;
   assign busy      = state_q != IDLE;
   assign txd       = txd_q;
   assign tx_done   = done_q;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_data_d = hold_data_q;
      hold_full_d = hold_full_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      par_d       = par_q;
      txd_d       = txd_q;
      done_d      = 1'b0;
      if (tx_valid && !hold_full_q) begin
         hold_data_d = tx_data;
         hold_full_d = 1'b1;
      end
      if (bit_tick) begin
         case (state_q)
            START: begin
               txd_d     = shift_q[0];
               bit_cnt_d = '0;
               state_d   = DATA;
            end
            DATA: begin
               if (bit_cnt_q != LAST_BIT) begin
                  shift_d   = shift_q >> 1;
                  txd_d     = shift_q[1];
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end else begin
                  txd_d      = PARITY_EN ? par_q : 1'b1;
                  stop_cnt_d = '0;
                  state_d    = PARITY_EN ? PARITY : STOP;
               end
            end
            PARITY: begin
               txd_d      = 1'b1;
               stop_cnt_d = '0;
               state_d    = STOP;
            end
            STOP: begin
               if (!last_stop) stop_cnt_d = stop_cnt_q + 1'b1;
               else begin
                  done_d  = 1'b1;
                  txd_d   = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
         // Next frame starts straight from IDLE or from the end of the last stop bit.
         if (hold_full_q && (state_q == IDLE || (state_q == STOP && last_stop))) begin
            shift_d     = hold_data_q;
            hold_full_d = 1'b0;
            par_d       = par_new;
            txd_d       = 1'b0;
            state_d     = START;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         hold_data_q <= '0;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= '0;
         stop_cnt_q  <= '0;
         par_q       <= 1'b0;
         txd_q       <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_data_q <= hold_data_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         par_q       <= par_d;
         txd_q       <= txd_d;
         done_q      <= done_d;
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx in three parameterisations sharing clock, reset and tick.
module tb_uart_tx;
   logic       clk = 1'b0, reset = 1'b0, bit_tick = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [2:0] vld = 3'b000;
   logic [2:0] rdy, txd, busy, done;
   int         n_chk = 0, n_fail = 0;
   int         dcnt[3] = '{0, 0, 0};

   // u0: even parity, 1 stop; u1: odd parity, 2 stops; u2: no parity, 1 stop
   uart_tx u0 (.clk(clk), .reset(reset), .bit_tick(bit_tick), .tx_data(tx_data), .tx_valid(vld[0]),
               .tx_ready(rdy[0]), .txd(txd[0]), .busy(busy[0]), .tx_done(done[0]));
   uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) u1 (
               .clk(clk), .reset(reset), .bit_tick(bit_tick), .tx_data(tx_data), .tx_valid(vld[1]),
               .tx_ready(rdy[1]), .txd(txd[1]), .busy(busy[1]), .tx_done(done[1]));
   uart_tx #(.PARITY_EN(1'b0)) u2 (
               .clk(clk), .reset(reset), .bit_tick(bit_tick), .tx_data(tx_data), .tx_valid(vld[2]),
               .tx_ready(rdy[2]), .txd(txd[2]), .busy(busy[2]), .tx_done(done[2]));

   always #5 clk = ~clk;

   always @(posedge clk)
      for (int i = 0; i < 3; i++) if (done[i]) dcnt[i]++;

   task automatic do_tick(input int gap);
      repeat (gap - 1) @(negedge clk);
      bit_tick = 1'b1;
      @(negedge clk);
      bit_tick = 1'b0;
   endtask

   task automatic send(input int i, input logic [7:0] b);
      tx_data = b;
      vld[i]  = 1'b1;
      @(negedge clk);
      vld[i]  = 1'b0;
   endtask

   task automatic test_reset;
      reset    = 1'b0;
      bit_tick = 1'b1;
      repeat (3) @(negedge clk);
      bit_tick = 1'b0;
      n_chk++; if (txd !== 3'b111) begin n_fail++; $display("FAIL reset_txd got %b exp 111", txd); end
      n_chk++; if (rdy !== 3'b111) begin n_fail++; $display("FAIL reset_ready got %b exp 111", rdy); end
      n_chk++; if (busy !== 3'b000) begin n_fail++; $display("FAIL reset_busy got %b exp 000", busy); end
      n_chk++; if (done !== 3'b000) begin n_fail++; $display("FAIL reset_done got %b exp 000", done); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_idle;
      for (int i = 0; i < 20; i++) begin
         do_tick(2);
         n_chk++;
         if ({txd, rdy, busy} !== 9'b111_111_000) begin
            n_fail++;
            $display("FAIL idle_%0d got txd=%b rdy=%b busy=%b exp 111/111/000", i, txd, rdy, busy);
         end
      end
   endtask

   task automatic test_even_a5;
      logic [0:10] exp = 11'b0_10100101_0_1;
      int d;
      send(0, 8'hA5);
      n_chk++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL a5_ready_drop got %b exp 0", rdy[0]); end
      repeat (3) @(negedge clk);
      n_chk++; if (txd[0] !== 1'b1) begin n_fail++; $display("FAIL a5_no_tick_start got %b exp 1", txd[0]); end
      d = dcnt[0];
      for (int i = 0; i < 11; i++) begin
         do_tick(4);
         n_chk++; if (txd[0] !== exp[i]) begin n_fail++; $display("FAIL a5_bit%0d got %b exp %b", i, txd[0], exp[i]); end
         if (i == 0) begin
            n_chk++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL a5_ready_back got %b exp 1", rdy[0]); end
            n_chk++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL a5_busy got %b exp 1", busy[0]); end
         end
      end
      do_tick(4);
      n_chk++; if ({done[0], txd[0]} !== 2'b11) begin n_fail++; $display("FAIL a5_done got done=%b txd=%b exp 1/1", done[0], txd[0]); end
      @(negedge clk);
      n_chk++; if ({done[0], busy[0]} !== 2'b00) begin n_fail++; $display("FAIL a5_idle got done=%b busy=%b exp 0/0", done[0], busy[0]); end
      n_chk++; if (dcnt[0] - d !== 1) begin n_fail++; $display("FAIL a5_done_count got %0d exp 1", dcnt[0] - d); end
   endtask

   task automatic test_odd_stop2;
      logic [0:11] exp = 12'b0_10000000_0_1_1;
      int d;
      send(1, 8'h01);
      d = dcnt[1];
      for (int i = 0; i < 12; i++) begin
         do_tick(3);
         n_chk++; if (txd[1] !== exp[i]) begin n_fail++; $display("FAIL odd01_bit%0d got %b exp %b", i, txd[1], exp[i]); end
         n_chk++; if (done[1] !== 1'b0) begin n_fail++; $display("FAIL odd01_early_done%0d got %b exp 0", i, done[1]); end
      end
      do_tick(3);
      n_chk++; if ({done[1], txd[1]} !== 2'b11) begin n_fail++; $display("FAIL odd01_done got done=%b txd=%b exp 1/1", done[1], txd[1]); end
      @(negedge clk);
      n_chk++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL odd01_idle got %b exp 0", busy[1]); end
      n_chk++; if (dcnt[1] - d !== 1) begin n_fail++; $display("FAIL odd01_done_count got %0d exp 1", dcnt[1] - d); end
   endtask

   task automatic test_back_to_back;
      logic [0:22] exp = 23'b0_10101010_0_1_0_11000011_0_1_1;
      int d;
      tx_data = 8'h55;
      vld[0]  = 1'b1;
      @(negedge clk);
      n_chk++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_drop got %b exp 0", rdy[0]); end
      tx_data = 8'hC3;
      d = dcnt[0];
      for (int i = 0; i < 23; i++) begin
         do_tick(4);
         n_chk++; if (txd[0] !== exp[i]) begin n_fail++; $display("FAIL b2b_bit%0d got %b exp %b", i, txd[0], exp[i]); end
         if (i == 0) begin
            n_chk++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_back got %b exp 1", rdy[0]); end
            @(negedge clk);
            n_chk++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept got %b exp 0", rdy[0]); end
            vld[0] = 1'b0;
         end
         if (i == 11 || i == 22) begin
            n_chk++; if (done[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_done_at%0d got %b exp 1", i, done[0]); end
         end
      end
      @(negedge clk);
      n_chk++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b exp 0", busy[0]); end
      n_chk++; if (dcnt[0] - d !== 2) begin n_fail++; $display("FAIL b2b_done_count got %0d exp 2", dcnt[0] - d); end
   endtask

   task automatic test_reset_mid;
      int d;
      send(0, 8'hFF);
      do_tick(4);
      send(0, 8'h12);
      n_chk++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL rst_hold_full got %b exp 0", rdy[0]); end
      for (int i = 0; i < 5; i++) do_tick(4);
      reset    = 1'b0;
      bit_tick = 1'b1;
      @(negedge clk);
      n_chk++; if ({txd[0], busy[0], rdy[0]} !== 3'b101) begin
         n_fail++; $display("FAIL rst_abort got txd=%b busy=%b rdy=%b exp 1/0/1", txd[0], busy[0], rdy[0]);
      end
      @(negedge clk);
      bit_tick = 1'b0;
      reset    = 1'b1;
      d = dcnt[0];
      for (int i = 0; i < 15; i++) begin
         do_tick(3);
         n_chk++; if ({txd[0], busy[0]} !== 2'b10) begin
            n_fail++; $display("FAIL rst_discard_%0d got txd=%b busy=%b exp 1/0", i, txd[0], busy[0]);
         end
      end
      n_chk++; if (dcnt[0] !== d) begin n_fail++; $display("FAIL rst_no_done got %0d exp %0d", dcnt[0], d); end
   endtask

   task automatic test_no_parity;
      logic [0:9] exp = 10'b0_00000001_1;
      logic prev = 1'b1;
      int d;
      send(2, 8'h80);
      d = dcnt[2];
      for (int p = 0; p < 11; p++) begin
         for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            n_chk++; if (txd[2] !== prev) begin n_fail++; $display("FAIL nopar_hold_p%0d_c%0d got %b exp %b", p, k, txd[2], prev); end
         end
         bit_tick = 1'b1;
         @(negedge clk);
         bit_tick = 1'b0;
         if (p < 10) begin
            n_chk++; if (txd[2] !== exp[p]) begin n_fail++; $display("FAIL nopar_bit%0d got %b exp %b", p, txd[2], exp[p]); end
            prev = exp[p];
         end else begin
            n_chk++; if ({done[2], txd[2]} !== 2'b11) begin n_fail++; $display("FAIL nopar_done got done=%b txd=%b exp 1/1", done[2], txd[2]); end
         end
      end
      @(negedge clk);
      n_chk++; if (dcnt[2] - d !== 1) begin n_fail++; $display("FAIL nopar_done_count got %0d exp 1", dcnt[2] - d); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_idle();
      test_even_a5();
      test_odd_stop2();
      test_back_to_back();
      test_reset_mid();
      test_no_parity();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
